image_line_feeder: RTL and testbench



---
 rtl/image_line_feeder.sv | 192 +++++++++++++++++++
 tb/tb_image_line_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_line_feeder.sv
// Credit-paced pixel source feeding the 3x3 window generator; one line credit per downstream line buffer.
// Optional one-zero-line framing above and below the image: define IMAGE_LINE_FEEDER_ZERO_PAD_EN.
module image_line_feeder #(
    parameter int IMG_WIDTH    = 512,
    parameter int IMG_HEIGHT   = 512,
    parameter int NUM_LINE_BUF = 4,
    parameter int PIX_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [PIX_W-1:0] i_pixel_data,
    input  logic             i_pixel_valid,
    output logic             o_pixel_ready,
    output logic [PIX_W-1:0] o_pixel_data,
    output logic             o_pixel_data_valid,
    input  logic             i_intr,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_err
);

    localparam int PCW = $clog2(IMG_WIDTH);
    localparam int LCW = $clog2(IMG_HEIGHT + 3);
    localparam int CCW = $clog2(NUM_LINE_BUF + 1);
`ifdef IMAGE_LINE_FEEDER_ZERO_PAD_EN
    localparam int TOTAL_LINES = IMG_HEIGHT + 2;
    localparam int EXP_INTR    = IMG_HEIGHT;
`else
    localparam int TOTAL_LINES = IMG_HEIGHT;
    localparam int EXP_INTR    = IMG_HEIGHT - 2;
`endif

    localparam logic [PCW-1:0] PIX_LAST  = PCW'(IMG_WIDTH - 1);
    localparam logic [PCW-1:0] PIX_ONE   = PCW'(1);
    localparam logic [LCW-1:0] LINE_LAST = LCW'(TOTAL_LINES - 1);
    localparam logic [LCW-1:0] LINE_ONE  = LCW'(1);
    localparam logic [LCW-1:0] INTR_EXP  = LCW'(EXP_INTR);
    localparam logic [CCW-1:0] CRED_MAX  = CCW'(NUM_LINE_BUF);
    localparam logic [CCW-1:0] CRED_ONE  = CCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PCW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [LCW-1:0]     line_cnt_q, line_cnt_d;
    logic [LCW-1:0]     intr_cnt_q, intr_cnt_d;
    logic [CCW-1:0]     credits_q, credits_d;
    logic [PIX_W-1:0]   pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;

    logic               src_upstream_s;
    logic               send_ok_s;
    logic               fire_s;
    logic               line_end_s;
    logic               intr_s;
    logic               intr_overflow_s;

    // Zero lines are generated internally, so the upstream is only consulted for image lines.
`ifdef IMAGE_LINE_FEEDER_ZERO_PAD_EN
    assign src_upstream_s = (line_cnt_q != {LCW{1'b0}}) && (line_cnt_q != LINE_LAST);
`else
    assign src_upstream_s = 1'b1;
`endif

    assign send_ok_s       = (state_q == ST_SEND) && (credits_q != {CCW{1'b0}});
    assign o_pixel_ready   = send_ok_s && src_upstream_s;
    assign fire_s          = send_ok_s && (src_upstream_s ? i_pixel_valid : 1'b1);
    assign line_end_s      = fire_s && (pix_cnt_q == PIX_LAST);
    assign intr_s          = i_intr && ((state_q == ST_SEND) || (state_q == ST_DRAIN));
    // A credit returned in the same cycle a line completes is paired with it, so it cannot overflow.
    assign intr_overflow_s = intr_s && !line_end_s && (credits_q == CRED_MAX);

    // Next-state, counters, credits and output registers.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        intr_cnt_d   = intr_cnt_q;
        credits_d    = credits_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = err_q || intr_overflow_s || (i_intr && (state_q == ST_DONE));

        if (fire_s) begin
            pix_valid_d = 1'b1;
            pix_data_d  = src_upstream_s ? i_pixel_data : {PIX_W{1'b0}};
            if (line_end_s) begin
                pix_cnt_d  = {PCW{1'b0}};
                line_cnt_d = line_cnt_q + LINE_ONE;
            end else begin
                pix_cnt_d  = pix_cnt_q + PIX_ONE;
            end
        end else begin
            pix_valid_d = 1'b0;
        end

        if (intr_s) begin
            intr_cnt_d = intr_cnt_q + LINE_ONE;
        end else begin
            intr_cnt_d = intr_cnt_q;
        end

        case ({line_end_s, intr_s})
            2'b10:   credits_d = credits_q - CRED_ONE;
            2'b01:   credits_d = (credits_q == CRED_MAX) ? credits_q : credits_q + CRED_ONE;
            default: credits_d = credits_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_SEND;
                    busy_d     = 1'b1;
                    pix_cnt_d  = {PCW{1'b0}};
                    line_cnt_d = {LCW{1'b0}};
                    intr_cnt_d = {LCW{1'b0}};
                    credits_d  = CRED_MAX;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (line_end_s && (line_cnt_q == LINE_LAST)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DRAIN: begin
                if (intr_cnt_q == INTR_EXP) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d      = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= {PCW{1'b0}};
            line_cnt_q   <= {LCW{1'b0}};
            intr_cnt_q   <= {LCW{1'b0}};
            credits_q    <= CRED_MAX;
            pix_data_q   <= {PIX_W{1'b0}};
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            intr_cnt_q   <= intr_cnt_d;
            credits_q    <= credits_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign o_pixel_data       = pix_data_q;
    assign o_pixel_data_valid = pix_valid_q;
    assign o_busy             = busy_q;
    assign o_frame_done       = frame_done_q;
    assign o_err              = err_q;

endmodule

// File: tb/tb_image_line_feeder.sv
// Bench for image_line_feeder on a reduced 32x12 image: vector table, credit stall/resume,
// same-cycle credit return, full frame with a downstream model, error and reset behaviour.
module tb_image_line_feeder;

    localparam int W   = 32;
    localparam int H   = 12;
    localparam int NB  = 4;
    localparam int DLY = 20;
`ifdef IMAGE_LINE_FEEDER_ZERO_PAD_EN
    localparam int TOTAL = H + 2;
    localparam int EXP   = H;
    localparam bit PAD   = 1'b1;
`else
    localparam int TOTAL = H;
    localparam int EXP   = H - 2;
    localparam bit PAD   = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_pixel_data = 8'h00;
    logic       i_pixel_valid = 1'b0;
    logic       i_intr;
    logic       o_pixel_ready;
    logic [7:0] o_pixel_data;
    logic       o_pixel_data_valid;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;

    logic       man_intr = 1'b0;
    logic       ds_intr = 1'b0;
    assign i_intr = man_intr | ds_intr;

    image_line_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LINE_BUF(NB), .PIX_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_pixel_data(i_pixel_data), .i_pixel_valid(i_pixel_valid),
        .o_pixel_ready(o_pixel_ready), .o_pixel_data(o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid), .i_intr(i_intr),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Upstream source plus output scoreboard: drives just after negedge, samples just before posedge.
    int         src_mode = 0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic [7:0] src_val = 8'h00;
    logic [7:0] up_q[$];
    int out_cnt = 0, xfer_cnt = 0, done_cnt = 0, stream_err = 0, cyc = 0, done_cyc = 0;
    always begin
        @(negedge i_clk);
        #1;
        case (src_mode)
            0:       i_pixel_valid = 1'b0;
            1:       i_pixel_valid = 1'b1;
            2:       i_pixel_valid = 1'($urandom_range(0, 1));
            default: i_pixel_valid = tb_valid;
        endcase
        i_pixel_data = (src_mode == 3) ? tb_data : src_val;
        #3;
        cyc++;
        if (i_rst) begin
            up_q.delete();
            out_cnt = 0; xfer_cnt = 0; done_cnt = 0;
        end else begin
            if (o_pixel_data_valid) begin
                int line;
                logic [7:0] exp_pix;
                line = out_cnt / W;
                if (PAD && (line == 0 || line == TOTAL - 1)) exp_pix = 8'h00;
                else if (up_q.size() == 0) begin exp_pix = ~o_pixel_data; end
                else exp_pix = up_q.pop_front();
                if (o_pixel_data !== exp_pix) stream_err++;
                out_cnt++;
            end
            if (i_pixel_valid && o_pixel_ready) begin
                up_q.push_back(i_pixel_data);
                xfer_cnt++;
                if (src_mode != 3) src_val = src_val + 8'd1;
            end
            if (o_frame_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    // Downstream model: returns one credit DLY cycles after three more lines are buffered.
    logic ds_en = 1'b0;
    int   ds_sent = 0, last_intr_cyc = 0;
    always begin
        @(negedge i_clk);
        if (i_rst || !ds_en) begin
            ds_sent = 0;
        end else if (ds_sent < EXP && (out_cnt / W) >= ds_sent + 3) begin
            repeat (DLY - 1) @(negedge i_clk);
            ds_intr = 1'b1;
            last_intr_cyc = cyc + 1;
            @(negedge i_clk);
            ds_intr = 1'b0;
            ds_sent++;
        end
    end

    typedef struct {
        logic start; logic valid; logic [7:0] data; logic intr;
        logic exp_ready; logic exp_dvalid; logic [7:0] exp_data; logic exp_busy; logic exp_err;
    } vec_t;
    vec_t vecs[8];

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    initial begin
        //          start valid data  intr  ready dval  data  busy  err
        vecs[0] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};

        repeat (3) @(negedge i_clk);
        #2;
        chk("rst_ready", int'(o_pixel_ready), 0);
        chk("rst_dvalid", int'(o_pixel_data_valid), 0);
        chk("rst_data", int'(o_pixel_data), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_frame_done), 0);
        chk("rst_err", int'(o_err), 0);
        i_rst = 1'b0;

`ifndef IMAGE_LINE_FEEDER_ZERO_PAD_EN
        src_mode = 3;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            i_start = vecs[i].start; man_intr = vecs[i].intr;
            tb_valid = vecs[i].valid; tb_data = vecs[i].data;
            #2;
            chk($sformatf("vec%0d_ready", i), int'(o_pixel_ready), int'(vecs[i].exp_ready));
            @(posedge i_clk);
            #1;
            chk($sformatf("vec%0d_dvalid", i), int'(o_pixel_data_valid), int'(vecs[i].exp_dvalid));
            chk($sformatf("vec%0d_data", i), int'(o_pixel_data), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_busy", i), int'(o_busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_err", i), int'(o_err), int'(vecs[i].exp_err));
        end
        @(negedge i_clk);
        i_start = 1'b0; man_intr = 1'b0; tb_valid = 1'b0;
        src_mode = 0;
        do_reset();
`endif

        // Four credits: exactly NB lines go out, then the source is held off.
        src_mode = 1;
        pulse_start();
        repeat (NB * W + 30) @(negedge i_clk);
        #2;
        chk("stall_pixels", out_cnt, NB * W);
        chk("stall_ready", int'(o_pixel_ready), 0);
        chk("stall_busy", int'(o_busy), 1);
        man_intr = 1'b1;
        @(negedge i_clk);
        man_intr = 1'b0;
        repeat (W + 30) @(negedge i_clk);
        #2;
        chk("resume_pixels", out_cnt, (NB + 1) * W);
        chk("resume_ready", int'(o_pixel_ready), 0);
        chk("resume_stream", stream_err, 0);

        // Credit returned on the exact cycle the last pixel of a line transfers.
        @(negedge i_clk);
        man_intr = 1'b1;
        @(negedge i_clk);
        man_intr = 1'b0;
        repeat (W - 1) @(negedge i_clk);
        man_intr = 1'b1;
        @(negedge i_clk);
        man_intr = 1'b0;
        #2;
        chk("same_cycle_ready", int'(o_pixel_ready), 1);
        chk("same_cycle_count", out_cnt, (NB + 2) * W - 1);
        repeat (W - 1) @(negedge i_clk);
        #2;
        chk("no_gap_count", out_cnt, (NB + 3) * W - 2);
        repeat (20) @(negedge i_clk);
        #2;
        chk("same_cycle_total", out_cnt, (NB + 3) * W);
        chk("same_cycle_stall", int'(o_pixel_ready), 0);
        chk("same_cycle_stream", stream_err, 0);

        // Full frame with random upstream valid and a stray start pulse mid-frame.
        src_mode = 0;
        do_reset();
        src_mode = 2;
        ds_en = 1'b1;
        pulse_start();
        repeat (60) @(negedge i_clk);
        pulse_start();
        for (int i = 0; i < 6000 && done_cnt == 0; i++) @(negedge i_clk);
        #2;
        chk("frame_done_pulses", done_cnt, 1);
        chk("frame_out_pixels", out_cnt, TOTAL * W);
        chk("frame_in_pixels", xfer_cnt, H * W);
        chk("frame_intr", ds_sent, EXP);
        chk("frame_done_latency", done_cyc - last_intr_cyc, 2);
        chk("frame_stream", stream_err, 0);
        chk("frame_leftover", up_q.size(), 0);
        chk("frame_err", int'(o_err), 0);
        repeat (10) @(negedge i_clk);
        #2;
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_ready", int'(o_pixel_ready), 0);
        chk("idle_done_once", done_cnt, 1);
        ds_en = 1'b0;

        // Credit returned with all credits still held, then reset in mid-line.
        src_mode = 0;
        do_reset();
        src_mode = 1;
        pulse_start();
        man_intr = 1'b1;
        @(negedge i_clk);
        man_intr = 1'b0;
        repeat (NB * W + 30) @(negedge i_clk);
        #2;
        chk("ovf_err", int'(o_err), 1);
        chk("ovf_credits", out_cnt, NB * W);
        chk("ovf_ready", int'(o_pixel_ready), 0);
        man_intr = 1'b1;
        @(negedge i_clk);
        man_intr = 1'b0;
        repeat (W / 2) @(negedge i_clk);
        #2;
        chk("midline_dvalid", int'(o_pixel_data_valid), 1);
        chk("midline_err_sticky", int'(o_err), 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mrst_ready", int'(o_pixel_ready), 0);
        chk("mrst_dvalid", int'(o_pixel_data_valid), 0);
        chk("mrst_data", int'(o_pixel_data), 0);
        chk("mrst_busy", int'(o_busy), 0);
        chk("mrst_done", int'(o_frame_done), 0);
        chk("mrst_err", int'(o_err), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        src_mode = 0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
